// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM states, address field layout, default slave count
// and the latched command struct used by the master port.
package bus_pkg;

  localparam int BUS_NUM_SLAVES = 3;
  localparam int BUS_ADDR_W     = 16;
  localparam int BUS_DATA_W     = 8;

  localparam int SLV_IDX_LSB = 11;
  localparam int SLV_IDX_W   = 2;
  localparam int SLV_OFS_W   = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_RESP,
    S_ERR
  } bus_state_e;

  typedef struct packed {
    logic                  mode;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decode: one-hot slave select plus decode-error flag.
// Shared between the master port and the interconnect.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = BUS_NUM_SLAVES
) (
  input  logic [BUS_ADDR_W-1:0] addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  err
);

  localparam int HI_LSB = SLV_IDX_LSB + SLV_IDX_W;

  logic                 hi_bad;
  logic [SLV_IDX_W-1:0] idx;
  logic                 unused_ofs;

  assign hi_bad     = |addr[BUS_ADDR_W-1:HI_LSB];
  assign idx        = addr[SLV_IDX_LSB +: SLV_IDX_W];
  assign unused_ofs = ^addr[SLV_OFS_W-1:0];

  // Indices with no populated slave never match, so they fall into err.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
    assign sel[i] = !hi_bad && (idx == SLV_IDX_W'(i));
  end

  assign err = ~|sel;

endmodule

// File: rtl/bus_master_port.sv
// Master-side bus port: one request at a time, decode, valid pulse, wait for
// ready, one-cycle response. Optional WAIT timeout under `BUS_TIMEOUT_EN.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = BUS_NUM_SLAVES,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_mode,
  input  logic [BUS_ADDR_W-1:0]   req_addr,
  input  logic [BUS_DATA_W-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [BUS_DATA_W-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [NUM_SLAVES-1:0]   sl,
  output logic                    valid,
  output logic                    mode,
  output logic [BUS_ADDR_W-1:0]   addr,
  output logic [BUS_DATA_W-1:0]   wdata,
  input  logic [NUM_SLAVES-1:0]   ready,
  input  logic [NUM_SLAVES*8-1:0] rdata
);

  bus_state_e              state_q, state_d;
  bus_cmd_t                cmd_q;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_err;
  logic                    accept;
  logic                    hit;
  logic                    tmo_hit;
  logic [BUS_DATA_W-1:0]   rd_sel;

  bus_addr_decode #(.NUM_SLAVES(NUM_SLAVES)) u_dec (
    .addr (req_addr),
    .sel  (dec_sel),
    .err  (dec_err)
  );

  assign accept = (state_q == S_IDLE) && req_valid && req_ready;
  assign hit    = |(ready & sl);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sl[i]) rd_sel = rd_sel | rdata[8*i +: 8];
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  tmo_cnt <= '0;
    else if (state_q == S_ADDR)  tmo_cnt <= '0;
    else if (state_q == S_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ready in the expiry cycle is checked first, so it wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = dec_err ? S_ERR : S_ADDR;
      S_ADDR: state_d = S_WAIT;
      S_WAIT: begin
        if (hit)          state_d = S_RESP;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All bus and response outputs are registered off the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      valid     <= 1'b0;
      sl        <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      cmd_q     <= '0;
    end else begin
      req_ready <= (state_d == S_IDLE);
      valid     <= (state_d == S_ADDR);
      rsp_valid <= (state_d == S_RESP) || (state_d == S_ERR);
      rsp_err   <= (state_d == S_ERR);
      rsp_rdata <= (state_q == S_WAIT && hit && !cmd_q.mode) ? rd_sel : '0;
      if (accept) begin
        cmd_q <= '{mode: req_mode, addr: req_addr, wdata: req_wdata};
        sl    <= dec_sel;
      end else if (state_d != S_WAIT) begin
        sl    <= '0;
      end
    end
  end

  assign mode  = cmd_q.mode;
  assign addr  = cmd_q.addr;
  assign wdata = cmd_q.wdata;

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: behavioural slaves, reference memory
// model, decoupled response and bus-command monitors.
module tb_bus_master_port;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_mode;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [2:0]  sl;
  logic        valid, mode;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [2:0]  ready_w;
  logic [23:0] rdata_w;

  localparam int TMO = 15;

  bus_master_port #(.NUM_SLAVES(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sl(sl), .valid(valid), .mode(mode), .addr(addr), .wdata(wdata),
    .ready(ready_w), .rdata(rdata_w)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, last_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural 2 KB slaves: capture at the valid edge, ready three edges later.
  logic [7:0]  slv_mem [3][2048];
  int          scnt [3];
  logic        s_mode [3];
  logic [10:0] s_ofs [3];
  logic [7:0]  s_wd [3];
  logic [2:0]  slv_ready, spur;
  logic [23:0] slv_rdata, spur_rd;
  bit          stall;

  assign ready_w = slv_ready | spur;
  assign rdata_w = slv_rdata ^ spur_rd;

  initial begin
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 2048; k++) slv_mem[i][k] <= 8'(i * 29 + k * 7 + 3);
    for (int i = 0; i < 3; i++) scnt[i] <= 0;
    slv_ready <= '0;
    slv_rdata <= '0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      slv_ready[i] <= 1'b0;
      if (valid && sl[i]) begin
        scnt[i]   <= 3;
        s_mode[i] <= mode;
        s_ofs[i]  <= addr[10:0];
        s_wd[i]   <= wdata;
      end else if (scnt[i] > 0) begin
        scnt[i] <= scnt[i] - 1;
        if (scnt[i] == 1 && !stall) begin
          slv_ready[i] <= 1'b1;
          if (s_mode[i]) begin
            slv_mem[i][s_ofs[i]] <= s_wd[i];
            slv_rdata[8*i +: 8]  <= 8'h00;
          end else begin
            slv_rdata[8*i +: 8]  <= slv_mem[i][s_ofs[i]];
          end
        end
      end
    end
  end

  // Reference model and scoreboards
  typedef struct { logic err; logic [7:0] rd; int due; } rsp_t;
  typedef struct { logic [2:0] sl; logic m; logic [15:0] a; logic [7:0] d; } cmd_t;
  rsp_t       sb_q [$];
  cmd_t       bus_q [$];
  logic [7:0] ref_mem [3][2048];

  always @(negedge clk) begin : rsp_mon
    rsp_t e;
    if (rst_n && rsp_valid) begin
      if (sb_q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_cycle", cyc, e.due);
        chk("sl_idle_in_rsp", sl, 0);
      end
    end
  end

  logic prev_valid = 0, prev_rsp = 0;
  always @(negedge clk) begin : bus_mon
    cmd_t e;
    if (rst_n && prev_rsp && !rsp_valid) chk("rdata_cleared", rsp_rdata, 0);
    if (rst_n && valid) begin
      chk("valid_is_pulse", prev_valid, 0);
      if (bus_q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = bus_q.pop_front();
        chk("bus_sl", sl, e.sl);
        chk("bus_mode", mode, e.m);
        chk("bus_addr", addr, e.a);
        chk("bus_wdata", wdata, e.d);
      end
    end
    prev_valid <= valid;
    prev_rsp   <= rsp_valid;
  end

  task automatic send(input logic m, input logic [15:0] a, input logic [7:0] d,
                      input int gap, input bit hold, input bit tmo);
    int   c, idx;
    bit   ok, derr;
    rsp_t r;
    @(negedge clk);
    req_valid = 1; req_mode = m; req_addr = a; req_wdata = d;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("accept_wait_expired", 0, 1);
    c    = cyc;
    idx  = int'(a[12:11]);
    derr = (a[15:13] != 0) || (idx >= 3);
    if (derr) begin
      r = '{err: 1'b1, rd: 8'h00, due: c + 1};
    end else begin
      bus_q.push_back('{sl: 3'(1 << idx), m: m, a: a, d: d});
      if (tmo) r = '{err: 1'b1, rd: 8'h00, due: c + 2 + TMO};
      else if (m) begin
        ref_mem[idx][a[10:0]] = d;
        r = '{err: 1'b0, rd: 8'h00, due: c + 6};
      end else r = '{err: 1'b0, rd: ref_mem[idx][a[10:0]], due: c + 6};
    end
    sb_q.push_back(r);
    if (gap > 0) chk("req_to_req_cycles", c - last_acc, gap);
    last_acc = c;
    @(posedge clk);
    @(negedge clk);
    chk("req_ready_busy", req_ready, 0);
    if (!hold) req_valid = 0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_mode = 0; req_addr = '0; req_wdata = '0;
    spur = '0; spur_rd = '0; stall = 0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 2048; k++) ref_mem[i][k] = 8'(i * 29 + k * 7 + 3);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_outs", {sl, valid, rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_cmd", {mode, addr, wdata}, 0);
    #2 rst_n = 1;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1);

    // Write then read slave 1, back to back
    send(1, 16'h0810, 8'h5A, 0, 1, 0);
    send(0, 16'h0810, 8'h00, 7, 0, 0);
    wait_drain();

    // Decode errors
    send(0, 16'h1800, 8'h00, 0, 1, 0);
    send(0, 16'h2000, 8'h00, 2, 0, 0);
    wait_drain();

    // Three requests with req_valid held throughout
    send(1, 16'h0004, 8'hC3, 0, 1, 0);
    send(1, 16'h1004, 8'h3C, 7, 1, 0);
    send(0, 16'h0004, 8'h00, 7, 0, 0);
    wait_drain();

    // Spurious ready while idle and from an unselected slave
    @(negedge clk); spur = 3'b010; spur_rd = 24'h00FF00;
    @(negedge clk); spur = '0; spur_rd = '0;
    send(0, 16'h0810, 8'h00, 0, 0, 0);
    @(negedge clk); spur = 3'b001; spur_rd = 24'h0000FF;
    @(negedge clk); spur = '0; spur_rd = '0;
    wait_drain();

`ifdef BUS_TIMEOUT_EN
    stall = 1;
    send(0, 16'h0820, 8'h00, 0, 0, 1);
    wait_drain();
    repeat (3) @(negedge clk);
    spur = 3'b010;
    @(negedge clk); spur = '0;
    stall = 0;
    repeat (6) @(negedge clk);
    send(0, 16'h0820, 8'h00, 0, 0, 0);
    wait_drain();
`endif

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      if ($urandom_range(0, 4) == 0) a = 16'($urandom);
      else a = {3'b000, 2'($urandom_range(0, 2)), 7'd0, 4'($urandom_range(0, 15))};
      send(1'($urandom_range(0, 1)), a, 8'($urandom), 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();

    // Reset in the middle of WAIT abandons the read
    send(0, 16'h0004, 8'h00, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_outs", {sl, valid, rsp_valid, rsp_err, rsp_rdata, req_ready}, 0);
    chk("async_rst_cmd", {mode, addr, wdata}, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    #1 chk("req_ready_low_before_edge", req_ready, 0);
    @(posedge clk); #1;
    chk("req_ready_first_edge", req_ready, 1);
    repeat (10) @(negedge clk);
    send(0, 16'h1004, 8'h00, 0, 0, 0);
    wait_drain();
    chk("bus_q_drained", bus_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
